// File: rtl/simple_risc_pkg.sv
// ---------------------------------------------------------------------------
// | Package     : simple_risc_pkg                                            |
// | Description : Opcodes, sequencer states and PC select codes for the      |
// |               SimpleRISC multi-cycle control path.                       |
// | Revision    : 1.0  initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

package simple_risc_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_DIV  = 3;
  localparam int OP_MOD  = 4;
  localparam int OP_CMP  = 5;
  localparam int OP_AND  = 6;
  localparam int OP_OR   = 7;
  localparam int OP_NOT  = 8;
  localparam int OP_MOV  = 9;
  localparam int OP_LSL  = 10;
  localparam int OP_LSR  = 11;
  localparam int OP_ASR  = 12;
  localparam int OP_NOP  = 13;
  localparam int OP_LD   = 14;
  localparam int OP_ST   = 15;
  localparam int OP_BEQ  = 16;
  localparam int OP_BGT  = 17;
  localparam int OP_B    = 18;
  localparam int OP_CALL = 19;
  localparam int OP_RET  = 20;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_RA     = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// | Module      : ctrl_decode                                                |
// | Description : Combinational opcode classification for the sequencer.    |
// | Revision    : 1.0  initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_decode
  import simple_risc_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] i_op,
  output logic           o_is_muldiv,
  output logic           o_is_mem,
  output logic           o_is_st,
  output logic           o_writes_rd,
  output logic           o_is_uncond,
  output logic           o_is_cond,
  output logic           o_is_ret,
  output logic           o_illegal
);

  always_comb begin
    o_is_muldiv = (i_op >= OPW'(OP_MUL)) && (i_op <= OPW'(OP_MOD));
    o_is_mem    = (i_op == OPW'(OP_LD)) || (i_op == OPW'(OP_ST));
    o_is_st     = (i_op == OPW'(OP_ST));
    // cmp, nop, st and the branches other than call leave the register file alone
    o_writes_rd = (i_op <= OPW'(OP_MOD))
               || ((i_op >= OPW'(OP_AND)) && (i_op <= OPW'(OP_ASR)))
               || (i_op == OPW'(OP_LD))
               || (i_op == OPW'(OP_CALL));
    o_is_uncond = (i_op == OPW'(OP_B)) || (i_op == OPW'(OP_CALL));
    o_is_cond   = (i_op == OPW'(OP_BEQ)) || (i_op == OPW'(OP_BGT));
    o_is_ret    = (i_op == OPW'(OP_RET));
    o_illegal   = (i_op > OPW'(OP_RET));
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// | Module      : multicycle_ctrl                                            |
// | Description : FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer.   |
// | Revision    : 1.0  initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import simple_risc_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int TIMEOUT = 64
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           branch_taken,
  input  logic           alu_done,
  input  logic           imem_ready,
  input  logic           dmem_ready,
  output logic           imem_req,
  output logic           if_en,
  output logic           id_en,
  output logic           ex_start,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic           isWb,
  output logic           isLd,
  output logic           isCall,
  output logic           pc_we,
  output logic [1:0]     pc_sel,
  output logic           halted,
  output logic           err,
  output logic [2:0]     state
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t         r_state;
  logic [OPW-1:0] r_op;
  logic           r_tk;
  logic           r_err;
  logic [WCW-1:0] r_wait;

  logic [OPW-1:0] w_dec_op;
  logic w_is_muldiv, w_is_mem, w_is_st, w_writes_rd;
  logic w_is_uncond, w_is_cond, w_is_ret, w_illegal;
  logic w_timeout, w_live, w_wb;

  // The legality check in DECODE must see the opcode before it is latched
  assign w_dec_op  = (r_state == S_DECODE) ? opcode : r_op;
  assign w_timeout = (r_wait == WCW'(TIMEOUT - 1));

  ctrl_decode #(.OPW(OPW)) u_decode (
    .i_op        (w_dec_op),
    .o_is_muldiv (w_is_muldiv),
    .o_is_mem    (w_is_mem),
    .o_is_st     (w_is_st),
    .o_writes_rd (w_writes_rd),
    .o_is_uncond (w_is_uncond),
    .o_is_cond   (w_is_cond),
    .o_is_ret    (w_is_ret),
    .o_illegal   (w_illegal)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_tk    <= 1'b0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_IDLE: if (run) r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) r_state <= S_DECODE;
          else if (w_timeout) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else r_wait <= r_wait + WCW'(1);
        end
        S_DECODE: begin
          r_op <= opcode;
          if (w_illegal) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (!w_is_muldiv || alu_done) begin
            r_tk    <= branch_taken;
            r_state <= w_is_mem ? S_MEMORY : S_WRITEBACK;
          end else if (w_timeout) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else r_wait <= r_wait + WCW'(1);
        end
        S_MEMORY: begin
          if (dmem_ready) r_state <= S_WRITEBACK;
          else if (w_timeout) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else r_wait <= r_wait + WCW'(1);
        end
        S_WRITEBACK: r_state <= run ? S_FETCH : S_IDLE;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Every strobe is held low while reset is asserted, whatever the old state
  assign w_live = !reset;
  assign w_wb   = w_live && (r_state == S_WRITEBACK);

  always_comb begin
    imem_req = w_live && (r_state == S_FETCH);
    if_en    = imem_req && imem_ready;
    id_en    = w_live && (r_state == S_DECODE);
    ex_start = w_live && (r_state == S_EXECUTE) && (r_wait == '0);
    dmem_req = w_live && (r_state == S_MEMORY);
    dmem_we  = dmem_req && w_is_st;
    pc_we    = w_wb;
    isWb     = w_wb && w_writes_rd;
    isLd     = w_wb && w_is_mem && !w_is_st;
    isCall   = w_wb && (r_op == OPW'(OP_CALL));
    pc_sel   = PC_SEL_NEXT;
    if (w_wb) begin
      if (w_is_ret) pc_sel = PC_SEL_RA;
      else if (w_is_uncond || (w_is_cond && r_tk)) pc_sel = PC_SEL_BRANCH;
    end
    halted   = w_live && (r_state == S_HALT);
    err      = w_live && r_err;
    state    = r_state;
  end

endmodule

`default_nettype wire
